// File: rtl/muldiv_hilo_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply/divide unit.
// The master issues ops; the slave owns HI/LO and reports busy/done.
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative radix-2 MULT/DIV unit owning HI/LO.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module muldiv_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_hilo_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opd;
  logic [WIDTH-1:0]   orig_a;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               ld_sgn;
  logic               ld_div;
  logic               ld_go;
  logic [WIDTH-1:0]   ld_a;
  logic [WIDTH-1:0]   ld_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_step;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    ld_sgn = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    ld_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    ld_go  = ld_sgn || ld_div || (bus.op == OP_MULTU);
    ld_a   = bus.a;
    ld_b   = bus.b;
    if (ld_sgn && bus.a[WIDTH-1]) ld_a = -bus.a;
    if (ld_sgn && bus.b[WIDTH-1]) ld_b = -bus.b;
  end

  // acc holds {partial, multiplier} for MULT and {remainder, quotient} for DIV
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) mul_sum = mul_sum + {1'b0, opd};
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, opd};
    if (!is_div)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      acc_step = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_r ? -acc[2*WIDTH-1:WIDTH]
                   : acc[2*WIDTH-1:WIDTH];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div && div_zero) begin
      fix_hi = orig_a;
      fix_lo = '1;
    end else if (is_div) begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opd      <= '0;
      orig_a   <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && bus.op == OP_MTHI)
            hi_q <= bus.a;
          if (bus.start && bus.op == OP_MTLO)
            lo_q <= bus.a;
          if (bus.start && ld_go) begin
            state    <= S_CALC;
            cnt      <= '0;
            is_div   <= ld_div;
            opd      <= ld_div ? ld_b : ld_a;
            acc      <= {{WIDTH{1'b0}},
                         ld_div ? ld_a : ld_b};
            orig_a   <= bus.a;
            neg_q    <= ld_sgn &
                        (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r    <= ld_sgn & bus.a[WIDTH-1];
            div_zero <= (bus.b == '0);
          end
        end
        S_CALC: begin
          if (bus.cancel) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!bus.cancel) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scenario bench for muldiv_hilo: scoreboard of expected {HI,LO}
// checked on every done pulse, plus per-scenario inline checks.
module tb_muldiv_hilo;

  localparam logic [2:0] NOP   = 3'b000;
  localparam logic [2:0] MULT  = 3'b001;
  localparam logic [2:0] MULTU = 3'b010;
  localparam logic [2:0] DIV   = 3'b011;
  localparam logic [2:0] DIVU  = 3'b100;
  localparam logic [2:0] MTHI  = 3'b101;
  localparam logic [2:0] MTLO  = 3'b110;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  res_t scb[$];

  always #5 clk = ~clk;

  muldiv_hilo_if #(.WIDTH(32)) bus ();

  muldiv_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic res_t model(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    res_t   r;
    int     sa, sbv;
    longint p;
    logic [63:0] pu;
    sa  = a;
    sbv = b;
    r   = '0;
    case (op)
      MULT: begin
        p = longint'(sa) * longint'(sbv);
        r = res_t'(p);
      end
      MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        r  = res_t'(pu);
      end
      DIV: begin
        if (b == 32'd0) r = '{hi: a, lo: 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          r = '{hi: 32'd0, lo: 32'h8000_0000};
        else r = '{hi: 32'(sa % sbv), lo: 32'(sa / sbv)};
      end
      DIVU: begin
        if (b == 32'd0) r = '{hi: a, lo: 32'hFFFF_FFFF};
        else r = '{hi: a % b, lo: a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      checks++;
      if (scb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done hi=%h lo=%h", bus.hi, bus.lo);
      end else begin
        res_t e;
        e = scb.pop_front();
        if ({bus.hi, bus.lo} !== e) begin
          errors++;
          $display("FAIL result got=%h_%h want=%h_%h",
                   bus.hi, bus.lo, e.hi, e.lo);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = NOP;
  endtask

  // counts busy samples until done; stops at a cycle budget
  task automatic wait_done(output int n, output bit ok);
    int t = 0;
    n = 0;
    while (bus.done !== 1'b1 && t < 100) begin
      if (bus.busy === 1'b1) n++;
      t++;
      @(negedge clk);
    end
    ok = (bus.done === 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0",
               bus.busy, bus.done);
    end
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo hi=%h lo=%h want 0 0", bus.hi, bus.lo);
    end
    rst = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int n;
    bit ok;
    scb.push_back(model(op, a, b));
    issue(op, a, b);
    wait_done(n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout done never seen", nm);
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL %s_busy_cycles got=%0d want=33", nm, n);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse done=%b want 0", nm, bus.done);
    end
  endtask

  task automatic test_mult;
    run_op("mult_neg3x5", MULT, 32'hFFFF_FFFD, 32'h5);
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL mult_const hi=%h lo=%h want FFFFFFFF FFFFFFF1",
               bus.hi, bus.lo);
    end
    run_op("multu_ff_x2", MULTU, 32'hFFFF_FFFF, 32'h2);
    checks++;
    if (bus.hi !== 32'h1 || bus.lo !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL multu_const hi=%h lo=%h want 00000001 FFFFFFFE",
               bus.hi, bus.lo);
    end
    run_op("mult_ff_x2", MULT, 32'hFFFF_FFFF, 32'h2);
    run_op("mult_minneg", MULT, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_div;
    run_op("div_neg7_2", DIV, 32'hFFFF_FFF9, 32'h2);
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_const hi=%h lo=%h want FFFFFFFF FFFFFFFD",
               bus.hi, bus.lo);
    end
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_ovf_const hi=%h lo=%h want 0 80000000",
               bus.hi, bus.lo);
    end
    run_op("divu_by0", DIVU, 32'h7, 32'h0);
    checks++;
    if (bus.hi !== 32'h7 || bus.lo !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL divu0_const hi=%h lo=%h want 7 FFFFFFFF",
               bus.hi, bus.lo);
    end
    run_op("div_by0", DIV, 32'hFFFF_FFFB, 32'h0);
    run_op("div_7_neg2", DIV, 32'h7, 32'hFFFF_FFFE);
    run_op("divu_big", DIVU, 32'hFFFF_FFF0, 32'h7);
  endtask

  task automatic test_mt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MTHI;
    bus.a     = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi hi=%h busy=%b want 12345678 0",
               bus.hi, bus.busy);
    end
    bus.op = MTLO;
    bus.a  = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = NOP;
    checks++;
    if (bus.lo !== 32'h9ABC_DEF0 || bus.hi !== 32'h1234_5678 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo hi=%h lo=%h busy=%b done=%b",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
  endtask

  task automatic test_cancel;
    bit saw_done = 1'b0;
    issue(DIV, 32'd100, 32'd3);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MTLO;
    bus.a     = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = NOP;
    repeat (3) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_busy busy=%b want 0", bus.busy);
    end
    repeat (40) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL cancel_done done=1 want 0");
    end
    checks++;
    if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL cancel_hilo hi=%h lo=%h want 12345678 9ABCDEF0",
               bus.hi, bus.lo);
    end
  endtask

  task automatic test_idle_cancel;
    int n;
    bit ok;
    scb.push_back(model(MULTU, 32'd9, 32'd11));
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = MULTU;
    bus.a      = 32'd9;
    bus.b      = 32'd11;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = NOP;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL idle_cancel_start busy=%b want 1", bus.busy);
    end
    wait_done(n, ok);
    checks++;
    if (!ok || n != 33) begin
      errors++;
      $display("FAIL idle_cancel_run ok=%b busy=%0d want 1 33", ok, n);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_midop;
    issue(MULT, 32'h1234_5678, 32'h0000_0777);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL rst_midop busy=%b done=%b hi=%h lo=%h",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    run_op("multu_3x4", MULTU, 32'd3, 32'd4);
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'h0000_000C) begin
      errors++;
      $display("FAIL multu_3x4_const hi=%h lo=%h want 0 0000000C",
               bus.hi, bus.lo);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bit ok;
    scb.push_back(model(DIV, 32'hFFFF_FF00, 32'd7));
    scb.push_back(model(MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFE));
    issue(DIV, 32'hFFFF_FF00, 32'd7);
    wait_done(n, ok);
    bus.start = 1'b1;
    bus.op    = MULT;
    bus.a     = 32'h7FFF_FFFF;
    bus.b     = 32'hFFFF_FFFE;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = NOP;
    wait_done(n, ok);
    checks++;
    if (!ok || n != 33) begin
      errors++;
      $display("FAIL b2b_second ok=%b busy=%0d want 1 33", ok, n);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = (i == 3) ? 32'd0 : $urandom;
      if (i == 5) b = b >> 20;
      run_op("random", op, a, b);
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = NOP;
    bus.a      = '0;
    bus.b      = '0;
    bus.cancel = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_cancel();
    test_idle_cancel();
    test_rst_midop();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got=%0d want=0", scb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the pipelined datapath.
- Sits in the EX stage beside the ALU and replaces single-cycle HI/LO multiply logic.
- Adds the following:
  - signed and unsigned MULT/DIV,
  - an iterative radix-2 engine with a busy/done handshake for pipeline stall control,
  - cancel for exception flush.

Parameters:
- WIDTH, 32: operand width in bits; HI and LO are each WIDTH bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  op request valid this cycle.
- op  input  3  op code: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (NOP).
- a  input  WIDTH  operand A (rs): multiplicand, dividend, or MTHI/MTLO data.
- b  input  WIDTH  operand B (rt): multiplier or divisor.
- cancel  input  1  abort in-flight MULT/DIV (exception flush).
- busy  output  1  high while a MULT/DIV is in flight; pipeline stalls MFHI/MFLO/MT*/new MULT/DIV on it.
- done  output  1  one-cycle pulse when a MULT/DIV result is written to HI/LO.
- hi  output  WIDTH  current HI register (MFHI source).
- lo  output  WIDTH  current LO register (MFLO source).

Behaviour:
- Reset (rst=1 at an edge):
  - state←IDLE; HI, LO, busy, done, and all internal registers ← 0.
  - Applies regardless of state, aborting any operation in flight.
- State machine: IDLE → CALC → FIX → IDLE.
- IDLE:
  - start with MTHI: HI←a next edge; LO unchanged. MTLO: LO←a. No busy, no done.
  - start with MULT/MULTU/DIV/DIVU: latch operands, go to CALC, busy=1 after that edge, counter←0.
  - Signed ops latch |a|, |b| and record sign flags. Unsigned ops latch raw values.
  - NOP/reserved: no effect.
- CALC:
  - One radix-2 step per edge, WIDTH edges total; counter increments and exits to FIX when counter==WIDTH-1.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX:
  - One edge; applies sign correction and writes HI/LO.
  - busy←0 and done←1 on that same edge; done is cleared the following edge.
- Latency: start sampled at edge 0 → CALC edges 1..WIDTH → FIX write at edge WIDTH+1. busy is high for exactly WIDTH+1 cycles.
- Results:
  - Multiply: {HI,LO} = full 2*WIDTH product. Signed product is negated iff the operand signs differ.
  - Divide: LO=quotient truncated toward zero; HI=remainder carrying the sign of the dividend.
- Division by zero: full latency still taken; HI←a (original dividend), LO←all ones. Applies to both signed and unsigned.
- Signed overflow (most-negative / −1): LO←most-negative, HI←0. No trap.
- start while busy: ignored entirely, including MTHI/MTLO; the pipeline must stall instead.
- cancel:
  - In CALC or FIX: next edge → IDLE, busy←0, done stays 0, HI/LO keep their pre-op values.
  - In IDLE: no effect; same-cycle start and cancel in IDLE accepts the start.
- rst has priority over cancel, which has priority over start.
- hi/lo outputs are direct register outputs; there is no forwarding of the result during FIX.

Test Plan:
- MULT a=FFFFFFFD (−3), b=00000005 → after 33 busy cycles, done pulse; HI=FFFFFFFF, LO=FFFFFFF1.
- MULTU a=FFFFFFFF, b=00000002 → HI=00000001, LO=FFFFFFFE. Then MULT with the same operands → HI=FFFFFFFF, LO=FFFFFFFE.
- DIV a=FFFFFFF9 (−7), b=2 → LO=FFFFFFFD, HI=FFFFFFFF. DIV a=80000000, b=FFFFFFFF → LO=80000000, HI=0. DIVU a=7, b=0 → HI=00000007, LO=FFFFFFFF.
- MTHI a=12345678, then MTLO a=9ABCDEF0 on consecutive cycles → hi/lo update one edge after each, with no busy and no done.
- Start DIV, pulse cancel at cycle 10 → busy low next edge, no done, HI/LO keep prior values. A MTLO issued while busy is ignored (LO unchanged).
- Start MULT, assert rst at cycle 20 → next edge busy=0, done=0, HI=LO=0. A fresh MULTU 3×4 then gives LO=0000000C, HI=0.
